// File: rtl/vrf_wb_ctrl.sv
//------------------------------------------------------------------------------
// vrf_wb_ctrl : sequences one vector-register write (req, per-element strobes, ready)
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vrf_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int LANES      = 4,
  parameter int ADDR_B     = $clog2(REG_NUM),
  parameter int ELEM_B     = $clog2(LANES)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wb_start_i,
  input  logic [ADDR_B-1:0]     wb_addr_i,
  input  logic [LANES-1:0]      wb_mask_i,
  input  logic                  res_valid_i,
  input  logic [DATA_WIDTH-1:0] res_data_i,
  output logic                  res_ready_o,
  output logic                  wr_req_o,
  output logic                  wr_en_o,
  output logic [ADDR_B-1:0]     wr_addr_o,
  output logic [ELEM_B-1:0]     wr_elem_cnt_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  wr_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  start_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ELEM_B-1:0] LAST_ELEM = ELEM_B'(LANES - 1);

  state_t              state_q;
  logic [ADDR_B-1:0]   addr_q;
  logic [LANES-1:0]    mask_q;
  logic [ELEM_B-1:0]   cnt_q;
  logic                req_q;
  logic                write_q;
  logic                busy_q;
  logic                done_q;

  logic                beat;
  logic                last_beat;

  // write_q mirrors S_WRITE so the beat strobes only combine a flop with res_valid_i
  assign beat      = write_q & res_valid_i;
  assign last_beat = beat & (cnt_q == LAST_ELEM);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wb_start_i) begin
            state_q <= S_REQ;
            addr_q  <= wb_addr_i;
            mask_q  <= wb_mask_i;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
          done_q <= 1'b0;
        end
        S_REQ: begin
          state_q <= S_WRITE;
          req_q   <= 1'b0;
          write_q <= 1'b1;
        end
        S_WRITE: begin
          if (last_beat) begin
            state_q <= S_DONE;
            write_q <= 1'b0;
            done_q  <= 1'b1;
          end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          write_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign res_ready_o   = write_q;
  assign wr_req_o      = req_q;
  assign wr_en_o       = beat & mask_q[cnt_q];
  assign wr_ready_o    = last_beat;
  assign wr_addr_o     = addr_q;
  assign wr_elem_cnt_o = cnt_q;
  assign wdata_o       = res_data_i;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign start_err_o   = wb_start_i & (state_q != S_IDLE);

endmodule

`default_nettype wire
